btn_event_decoder: RTL and testbench

Consumes a clean, debounced, synchronous push-button level and converts it into single-cycle event strobes: press, release, long-press and optional auto-repeat. It also keeps a wrapping press counter. It sits directly downstream of the button debounce stage and upstream of control FSMs and UI logic. Those consumers need discrete events, not levels.

---
 rtl/btn_evt_pkg.sv | 21 ++
 rtl/btn_hold_timer.sv | 29 ++
 rtl/btn_event_decoder.sv | 147 ++++++++++++++
 tb/tb_btn_event_decoder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// Shared types for the button event decoder.
// Holds the FSM state enum and the press counter width.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    WAIT_REL,
    IDLE,
    PRESSED,
    HELD
  } btn_evt_state_t;

  localparam int PRESS_COUNT_W = 8;

  function automatic int maxInt(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_hold_timer.sv
// Clearable hold counter with a loadable threshold.
// tc strobes on the enabled cycle where count equals threshold.
module btn_hold_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] threshold,
  output logic         tc
);

  logic [W-1:0] count;

  assign tc = enable && !clear && (count == threshold);

  // Wraps back to 0 on terminal count, so it never passes threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || tc) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/btn_event_decoder.sv
// Turns a debounced button level into press/release/long/repeat strobes.
// Auto-repeat is built only when BTN_EVT_REPEAT_EN is defined.
module btn_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btn_level,
  output logic                     press_pulse,
  output logic                     release_pulse,
  output logic                     long_pulse,
  output logic                     repeat_pulse,
  output logic                     held,
  output logic [PRESS_COUNT_W-1:0] press_count
);

`ifdef BTN_EVT_REPEAT_EN
  localparam int CNT_W =
    $clog2(maxInt(LONG_CYCLES, REPEAT_CYCLES));
  localparam logic [CNT_W-1:0] REP_TC =
    CNT_W'(REPEAT_CYCLES - 1);
`else
  localparam int CNT_W = $clog2(LONG_CYCLES);
`endif
  localparam logic [CNT_W-1:0] LONG_TC =
    CNT_W'(LONG_CYCLES - 1);

  generate
    if (LONG_CYCLES < 2) begin : gBadLong
      $error("LONG_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 2) begin : gBadRep
      $error("REPEAT_CYCLES must be >= 2");
    end
  endgenerate

  btn_evt_state_t state;
  btn_evt_state_t stateNext;

  logic             pressNext;
  logic             releaseNext;
  logic             longNext;
  logic             repeatNext;
  logic             tmrClear;
  logic             tmrEnable;
  logic             tmrTc;
  logic [CNT_W-1:0] tmrThresh;

  btn_hold_timer #(
    .W(CNT_W)
  ) uTimer (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmrClear),
    .enable   (tmrEnable),
    .threshold(tmrThresh),
    .tc       (tmrTc)
  );

  always_comb begin
    stateNext   = state;
    pressNext   = 1'b0;
    releaseNext = 1'b0;
    longNext    = 1'b0;
    repeatNext  = 1'b0;
    tmrClear    = 1'b0;
    tmrEnable   = 1'b0;
    tmrThresh   = LONG_TC;
    unique case (state)
      WAIT_REL: begin
        tmrClear = 1'b1;
        if (!btn_level) begin
          stateNext = IDLE;
        end
      end
      IDLE: begin
        tmrClear = 1'b1;
        if (btn_level) begin
          stateNext = PRESSED;
          pressNext = 1'b1;
        end
      end
      PRESSED: begin
        // Release wins over a threshold hit on the same edge.
        if (!btn_level) begin
          stateNext   = IDLE;
          releaseNext = 1'b1;
          tmrClear    = 1'b1;
        end else begin
          tmrEnable = 1'b1;
          if (tmrTc) begin
            stateNext = HELD;
            longNext  = 1'b1;
          end
        end
      end
      HELD: begin
`ifdef BTN_EVT_REPEAT_EN
        tmrThresh = REP_TC;
`endif
        if (!btn_level) begin
          stateNext   = IDLE;
          releaseNext = 1'b1;
          tmrClear    = 1'b1;
        end else begin
`ifdef BTN_EVT_REPEAT_EN
          tmrEnable = 1'b1;
          if (tmrTc) begin
            repeatNext = 1'b1;
          end
`endif
        end
      end
      default: begin
        stateNext = WAIT_REL;
        tmrClear  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= WAIT_REL;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
      press_count   <= '0;
    end else begin
      state         <= stateNext;
      press_pulse   <= pressNext;
      release_pulse <= releaseNext;
      long_pulse    <= longNext;
      repeat_pulse  <= repeatNext;
      held          <= (stateNext == PRESSED) ||
                       (stateNext == HELD);
      if (pressNext) begin
        press_count <= press_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Randomised + directed bench for btn_event_decoder.
// Reference model tracks press age in cycles with plain arithmetic.
module tb_btn_event_decoder;

  localparam int L = 8;
  localparam int R = 4;
`ifdef BTN_EVT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       btnLevel;
  logic       pressPulse;
  logic       releasePulse;
  logic       longPulse;
  logic       repeatPulse;
  logic       held;
  logic [7:0] pressCount;

  int nChecks;
  int nPass;

  bit       mArmed;
  bit       mActive;
  int       mAge;
  bit [7:0] mCount;
  bit       ePress;
  bit       eRelease;
  bit       eLong;
  bit       eRepeat;

  btn_event_decoder #(
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_level    (btnLevel),
    .press_pulse  (pressPulse),
    .release_pulse(releasePulse),
    .long_pulse   (longPulse),
    .repeat_pulse (repeatPulse),
    .held         (held),
    .press_count  (pressCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    nChecks++;
    if (obs === exp) begin
      nPass++;
    end else begin
      $display("FAIL %s: got %h want %h",
               tag, obs, exp);
    end
  endtask

  // One clock edge of the reference model, sampling b.
  task automatic modelEdge(input bit b);
    ePress   = 1'b0;
    eRelease = 1'b0;
    eLong    = 1'b0;
    eRepeat  = 1'b0;
    if (rst) begin
      mArmed  = 1'b0;
      mActive = 1'b0;
      mAge    = 0;
      mCount  = '0;
    end else if (!mArmed) begin
      if (!b) mArmed = 1'b1;
    end else if (!mActive) begin
      if (b) begin
        mActive = 1'b1;
        mAge    = 0;
        ePress  = 1'b1;
        mCount  = mCount + 8'd1;
      end
    end else if (!b) begin
      mActive  = 1'b0;
      eRelease = 1'b1;
    end else begin
      mAge++;
      eLong   = (mAge == L);
      eRepeat = REP_EN && (mAge > L) &&
                ((mAge - L) % R == 0);
    end
  endtask

  task automatic step(input bit b, input string tag);
    @(negedge clk);
    btnLevel = b;
    @(posedge clk);
    modelEdge(b);
    #1;
    checkVal(tag,
      {19'd0, pressPulse, releasePulse, longPulse,
       repeatPulse, held, pressCount},
      {19'd0, ePress, eRelease, eLong,
       eRepeat, mActive, mCount});
  endtask

  task automatic run(
    input bit    b,
    input int    n,
    input string tag
  );
    for (int i = 0; i < n; i++) step(b, tag);
  endtask

  initial begin
    nChecks  = 0;
    nPass    = 0;
    rst      = 1'b1;
    btnLevel = 1'b1;
    mArmed   = 1'b0;
    mActive  = 1'b0;
    mAge     = 0;
    mCount   = '0;
    run(1'b1, 3, "reset");
    rst = 1'b0;
    run(1'b1, 20, "waitrel_hi");
    run(1'b0, 3, "waitrel_lo");
    run(1'b1, 3, "short3");
    run(1'b0, 3, "short3_rel");
    run(1'b1, 20, "hold20");
    run(1'b0, 3, "hold20_rel");
    run(1'b1, L, "edge_rel");
    run(1'b0, 3, "edge_rel_lo");
    run(1'b1, 1, "one_cyc");
    run(1'b0, 2, "one_cyc_lo");
    for (int i = 0; i < 256; i++) begin
      step(1'b1, "wrap_hi");
      step(1'b0, "wrap_lo");
    end
    run(1'b1, 30, "hold30");
    run(1'b0, 2, "hold30_rel");
    run(1'b1, 5, "mid_press");
    @(negedge clk);
    rst = 1'b1;
    run(1'b1, 2, "mid_rst");
    rst = 1'b0;
    run(1'b1, 6, "mid_rst_hi");
    run(1'b0, 2, "mid_rst_lo");
    for (int i = 0; i < 120; i++) begin
      run(1'(i % 2),
          int'($urandom_range(1, 3 * L)),
          "random");
    end
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
